// File: rtl/sram_bist_pkg.sv
// Shared types for the SRAM march BIST.
// Holds the FSM state enum, the march element and phase enums, and a
// helper that gives the run length of a passing test for an address width.
package sram_bist_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // March C- style elements: M0 up(w0), M1 up(r0,w1), M2 up(r1,w0),
  // M3 down(r0,w1), M4 down(r1,w0), M5 down(r0)
  typedef enum logic [2:0] {M0, M1, M2, M3, M4, M5} elem_t;

  // R = read, W = write (compare + write), C = compare only
  typedef enum logic [1:0] {PH_R, PH_W, PH_C} phase_t;

  // One cycle per address in M0, two per address in M1..M5
  function automatic int unsigned total_cycles(input int unsigned addr_w);
    return 32'd11 * (32'd1 << addr_w);
  endfunction

endpackage

// File: rtl/bist_addr_gen.sv
// Up/down address counter for the march BIST.
// Ports: clk, rst (sync, active high), load (restart at first address of
// the direction given by load_down), step (advance one address),
// addr (current address), last (addr is the final address in this direction).
module bist_addr_gen #(
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              load_down,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic down;

  // Direction is latched on load so step needs no direction input
  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
      down <= 1'b0;
    end else if (load) begin
      down <= load_down;
      addr <= load_down ? '1 : '0;
    end else if (step) begin
      addr <= down ? (addr - ADDR_W'(1)) : (addr + ADDR_W'(1));
    end
  end

  assign last = down ? (addr == '0) : (addr == '1);

endmodule

// File: rtl/sram_march_bist.sv
// March BIST controller for a single-port SRAM with registered read data.
// Ports: clk, rst (sync, active high), start (test request, sampled in
// IDLE/DONE), mem_wr/mem_addr/mem_din (SRAM command), mem_dout (SRAM read
// data, valid the cycle after a read), busy/done/fail (status), and
// fail_elem/fail_addr/fail_exp/fail_act (first-mismatch record).
module sram_march_bist
  import sram_bist_pkg::*;
#(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [2:0]        fail_elem,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_exp,
  output logic [DATA_W-1:0] fail_act
);

  localparam logic [DATA_W-1:0] ZEROS = '0;
  localparam logic [DATA_W-1:0] ONES  = '1;

  state_t            state;
  elem_t             elem;
  phase_t            phase;
  logic              load_c;
  logic              load_down_c;
  logic              step_c;
  logic              last_c;
  logic              compare_c;
  logic              mismatch_c;
  logic [DATA_W-1:0] exp_c;
  logic [DATA_W-1:0] wpat_c;

  bist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (load_c),
    .load_down (load_down_c),
    .step      (step_c),
    .addr      (mem_addr),
    .last      (last_c)
  );

  // Expected read value, write pattern, compare point and address control
  always_comb begin
    load_c      = 1'b0;
    load_down_c = 1'b0;
    step_c      = 1'b0;
    exp_c       = (elem == M2 || elem == M4) ? ONES : ZEROS;
    wpat_c      = (elem == M1 || elem == M3) ? ONES : ZEROS;
    // Read data from the R cycle is on mem_dout during the following W/C cycle
    compare_c   = (state == RUN) &&
                  ((phase == PH_W && elem != M0) || phase == PH_C);
    mismatch_c  = compare_c && (mem_dout != exp_c);
    case (state)
      IDLE, DONE: begin
        if (start) load_c = 1'b1;
      end
      RUN: begin
        if (mismatch_c) begin
          load_c = 1'b1;                       // park address at 0
        end else if (phase != PH_R) begin
          if (last_c) begin
            load_c      = 1'b1;
            // M3..M5 run downwards; leaving M5 parks at 0
            load_down_c = (elem == M2 || elem == M3 || elem == M4);
          end else begin
            step_c = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Control FSM with registered SRAM command and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      elem      <= M0;
      phase     <= PH_R;
      mem_wr    <= 1'b0;
      mem_din   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fail      <= 1'b0;
      fail_elem <= '0;
      fail_addr <= '0;
      fail_exp  <= '0;
      fail_act  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= RUN;
            elem      <= M0;
            phase     <= PH_W;
            mem_wr    <= 1'b1;
            mem_din   <= ZEROS;
            busy      <= 1'b1;
            done      <= 1'b0;
            fail      <= 1'b0;
            fail_elem <= '0;
            fail_addr <= '0;
            fail_exp  <= '0;
            fail_act  <= '0;
          end
        end
        RUN: begin
          if (mismatch_c) begin
            state     <= DONE;
            mem_wr    <= 1'b0;
            mem_din   <= '0;
            busy      <= 1'b0;
            done      <= 1'b1;
            fail      <= 1'b1;
            fail_elem <= elem;
            fail_addr <= mem_addr;
            fail_exp  <= exp_c;
            fail_act  <= mem_dout;
          end else if (phase == PH_R) begin
            phase   <= (elem == M5) ? PH_C : PH_W;
            mem_wr  <= (elem != M5);
            mem_din <= (elem == M5) ? ZEROS : wpat_c;
          end else begin
            phase   <= PH_R;
            mem_wr  <= 1'b0;
            mem_din <= '0;
            if (last_c) begin
              if (elem == M5) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                elem <= elem_t'(3'(elem) + 3'd1);
              end
            end else if (elem == M0) begin
              // M0 is write-only: stay in W for the next address
              phase  <= PH_W;
              mem_wr <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
